// File: rtl/rvtu_mem_arb_n.sv
// rvtu_mem_arb_n: merges NREQ hold-until-resp requesters onto one cache port.
// Optional bus watchdog is built when RVTU_MEM_ARB_WDOG_EN is defined.
module rvtu_mem_arb_n #(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int WDOG_CYC  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NREQ*AW-1:0]        r_maddr,
  input  logic [NREQ-1:0]           r_mrd,
  input  logic [NREQ*DW/8-1:0]      r_mwr,
  input  logic [NREQ*DW-1:0]        r_mwdata,
  output logic [NREQ-1:0]           r_mresp,
  output logic [DW-1:0]             r_mrdata,
  output logic [AW-1:0]             c_maddr,
  output logic                      c_mrd,
  output logic [DW/8-1:0]           c_mwr,
  output logic [DW-1:0]             c_mwdata,
  input  logic                      c_mresp,
  input  logic [DW-1:0]             c_mrdata,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy,
  output logic                      wdog_err
);
  localparam int MW = DW / 8;
  localparam int GW = $clog2(NREQ);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_r;
  logic [GW-1:0]   gnt_r;
  logic [GW-1:0]   ptr_r;
  logic [GW-1:0]   base_s;
  logic [GW-1:0]   win_s;
  logic [GW:0]     sum_s;
  logic            win_vld_s;
  logic [NREQ-1:0] pend_s;
  logic            own_pend_s;
  logic            abandon_r;
  logic            wdog_hit_s;
  logic [AW-1:0]   win_addr_s;
  logic [MW-1:0]   win_mwr_s;
  logic [DW-1:0]   win_wdata_s;
  logic [AW-1:0]   c_maddr_r;
  logic            c_mrd_r;
  logic [MW-1:0]   c_mwr_r;
  logic [DW-1:0]   c_mwdata_r;
  logic            busy_r;

  // Pending = read strobe or any byte-write strobe.
  always_comb begin
    pend_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_s[i] = r_mrd[i] | (|r_mwr[i*MW +: MW]);
    end
  end

  // Winner search: nearest pending index after base, wrapping. Fixed priority is
  // the same scan anchored at NREQ-1, so index 0 is always looked at first.
  always_comb begin
    base_s    = (PRIO_MODE == 1) ? GW'(NREQ - 1) : ptr_r;
    win_s     = '0;
    win_vld_s = 1'b0;
    sum_s     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum_s     = {1'b0, base_s} + (GW+1)'(k);
      sum_s     = (sum_s >= (GW+1)'(NREQ)) ? (sum_s - (GW+1)'(NREQ)) : sum_s;
      win_s     = pend_s[sum_s[GW-1:0]] ? sum_s[GW-1:0] : win_s;
      win_vld_s = win_vld_s | pend_s[sum_s[GW-1:0]];
    end
  end

  // Payload of the selected requester and strobe status of the current owner.
  always_comb begin
    win_addr_s  = '0;
    win_mwr_s   = '0;
    win_wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_addr_s  = (win_s == GW'(i)) ? r_maddr[i*AW +: AW]  : win_addr_s;
      win_mwr_s   = (win_s == GW'(i)) ? r_mwr[i*MW +: MW]    : win_mwr_s;
      win_wdata_s = (win_s == GW'(i)) ? r_mwdata[i*DW +: DW] : win_wdata_s;
    end
    own_pend_s = pend_s[gnt_r];
  end

`ifdef RVTU_MEM_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wdog_cnt_r;
  logic          wdog_err_r;

  assign wdog_hit_s = (state_r == BUSY) && (wdog_cnt_r == CW'(WDOG_CYC - 1));

  // Watchdog: counts BUSY cycles, error latches until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_r <= '0;
      wdog_err_r <= 1'b0;
    end else begin
      wdog_cnt_r <= (state_r == BUSY) ? (wdog_cnt_r + CW'(1)) : '0;
      wdog_err_r <= wdog_err_r | (wdog_hit_s & ~c_mresp);
    end
  end

  assign wdog_err = wdog_err_r;
`else
  assign wdog_hit_s = 1'b0;
  assign wdog_err   = 1'b0;
`endif

  // Arbitration FSM with registered cache-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      c_maddr_r  <= '0;
      c_mrd_r    <= 1'b0;
      c_mwr_r    <= '0;
      c_mwdata_r <= '0;
      gnt_r      <= '0;
      busy_r     <= 1'b0;
      abandon_r  <= 1'b0;
      ptr_r      <= GW'(NREQ - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (!stall && win_vld_s) begin
            c_maddr_r  <= win_addr_s;
            c_mwdata_r <= win_wdata_s;
            c_mwr_r    <= win_mwr_s;
            c_mrd_r    <= ~(|win_mwr_s);
            gnt_r      <= win_s;
            busy_r     <= 1'b1;
            abandon_r  <= 1'b0;
            state_r    <= BUSY;
          end else begin
            c_mrd_r <= 1'b0;
            c_mwr_r <= '0;
            busy_r  <= 1'b0;
          end
        end
        BUSY: begin
          // A response in the watchdog's final cycle still completes normally.
          if (c_mresp || wdog_hit_s) begin
            c_mrd_r   <= 1'b0;
            c_mwr_r   <= '0;
            busy_r    <= 1'b0;
            abandon_r <= 1'b0;
            ptr_r     <= gnt_r;
            state_r   <= IDLE;
          end else begin
            abandon_r <= abandon_r | ~own_pend_s;
          end
        end
        default: begin
          state_r <= IDLE;
          c_mrd_r <= 1'b0;
          c_mwr_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Completion is steered to the owner unless it walked away.
  always_comb begin
    r_mresp = '0;
    if ((state_r == BUSY) && c_mresp && !abandon_r) begin
      r_mresp[gnt_r] = 1'b1;
    end else begin
      r_mresp = '0;
    end
  end

  assign r_mrdata = c_mrdata;
  assign c_maddr  = c_maddr_r;
  assign c_mrd    = c_mrd_r;
  assign c_mwr    = c_mwr_r;
  assign c_mwdata = c_mwdata_r;
  assign gnt_id   = gnt_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_rvtu_mem_arb_n.sv
// Bench for rvtu_mem_arb_n: a 4-requester round-robin instance and a 3-requester
// fixed-priority instance, with response scoreboards and a vector table.
module tb_rvtu_mem_arb_n;
  localparam int NA = 4;
  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             stall_a, c_mresp_a, c_mrd_a, busy_a, wdog_a;
  logic [NA*AW-1:0] maddr_a;
  logic [NA-1:0]    mrd_a, mresp_a;
  logic [NA*MW-1:0] mwr_a;
  logic [NA*DW-1:0] mwdata_a;
  logic [DW-1:0]    rdata_a, c_mwdata_a, c_mrdata_a;
  logic [AW-1:0]    c_maddr_a;
  logic [MW-1:0]    c_mwr_a;
  logic [1:0]       gnt_a;

  logic             stall_b, c_mresp_b, c_mrd_b, busy_b, wdog_b;
  logic [NB*AW-1:0] maddr_b;
  logic [NB-1:0]    mrd_b, mresp_b;
  logic [NB*MW-1:0] mwr_b;
  logic [NB*DW-1:0] mwdata_b;
  logic [DW-1:0]    rdata_b, c_mwdata_b, c_mrdata_b;
  logic [AW-1:0]    c_maddr_b;
  logic [MW-1:0]    c_mwr_b;
  logic [1:0]       gnt_b;

  rvtu_mem_arb_n #(.NREQ(NA), .AW(AW), .DW(DW), .PRIO_MODE(0), .WDOG_CYC(8)) u_rr (
    .clk(clk), .rst(rst), .stall(stall_a),
    .r_maddr(maddr_a), .r_mrd(mrd_a), .r_mwr(mwr_a), .r_mwdata(mwdata_a),
    .r_mresp(mresp_a), .r_mrdata(rdata_a),
    .c_maddr(c_maddr_a), .c_mrd(c_mrd_a), .c_mwr(c_mwr_a), .c_mwdata(c_mwdata_a),
    .c_mresp(c_mresp_a), .c_mrdata(c_mrdata_a),
    .gnt_id(gnt_a), .busy(busy_a), .wdog_err(wdog_a)
  );

  rvtu_mem_arb_n #(.NREQ(NB), .AW(AW), .DW(DW), .PRIO_MODE(1), .WDOG_CYC(8)) u_fp (
    .clk(clk), .rst(rst), .stall(stall_b),
    .r_maddr(maddr_b), .r_mrd(mrd_b), .r_mwr(mwr_b), .r_mwdata(mwdata_b),
    .r_mresp(mresp_b), .r_mrdata(rdata_b),
    .c_maddr(c_maddr_b), .c_mrd(c_mrd_b), .c_mwr(c_mwr_b), .c_mwdata(c_mwdata_b),
    .c_mresp(c_mresp_b), .c_mrdata(c_mrdata_b),
    .gnt_id(gnt_b), .busy(busy_b), .wdog_err(wdog_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          id;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_rd;
    logic [3:0]  exp_wr;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[4];
  int   rr_exp[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int id, input logic [31:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int id, input logic [31:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    q_b.push_back(e);
  endtask

  task automatic set_a(input int i, input logic rd, input logic [3:0] wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    mrd_a[i] = rd;
    mwr_a[i*MW +: MW] = wr;
    maddr_a[i*AW +: AW] = addr;
    mwdata_a[i*DW +: DW] = wd;
  endtask

  task automatic set_b(input int i, input logic rd, input logic [31:0] addr);
    mrd_b[i] = rd;
    mwr_b[i*MW +: MW] = 4'b0000;
    maddr_b[i*AW +: AW] = addr;
    mwdata_b[i*DW +: DW] = 32'h0;
  endtask

  // Scoreboard monitors: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (mresp_a !== 4'b0000) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_a_unexpected: got r_mresp 0x%0h, expected none", mresp_a);
      end else begin
        e = q_a.pop_front();
        chk("mon_a_mresp", 64'(mresp_a), 64'(4'b0001 << e.id));
        chk("mon_a_mrdata", 64'(rdata_a), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (mresp_b !== 3'b000) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_b_unexpected: got r_mresp 0x%0h, expected none", mresp_b);
      end else begin
        e = q_b.pop_front();
        chk("mon_b_mresp", 64'(mresp_b), 64'(3'b001 << e.id));
        chk("mon_b_mrdata", 64'(rdata_b), 64'(e.data));
      end
    end
  end

  initial begin
    vecs[0] = '{0, 1'b1, 4'b0000, 32'h4000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 3, 1'b1, 4'b0000};
    vecs[1] = '{1, 1'b1, 4'b0011, 32'h1000_0004, 32'h1234_5678, 32'h0BAD_F00D, 2, 1'b0, 4'b0011};
    vecs[2] = '{3, 1'b1, 4'b0000, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 32'h8000_0001, 0, 1'b1, 4'b0000};
    vecs[3] = '{2, 1'b0, 4'b1111, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0000, 1, 1'b0, 4'b1111};
    rr_exp  = '{0, 1, 2, 3, 0};

    rst = 1'b0;
    stall_a = 1'b0; maddr_a = '0; mrd_a = '0; mwr_a = '0; mwdata_a = '0;
    c_mresp_a = 1'b0; c_mrdata_a = '0;
    stall_b = 1'b0; maddr_b = '0; mrd_b = '0; mwr_b = '0; mwdata_b = '0;
    c_mresp_b = 1'b0; c_mrdata_b = '0;

    // Reset values.
    tick();
    chk("rst_c_mrd", 64'(c_mrd_a), 64'(1'b0));
    chk("rst_c_mwr", 64'(c_mwr_a), 64'(4'b0000));
    chk("rst_busy", 64'(busy_a), 64'(1'b0));
    chk("rst_gnt", 64'(gnt_a), 64'(2'd0));
    chk("rst_c_maddr", 64'(c_maddr_a), 64'(32'h0));
    chk("rst_c_mwdata", 64'(c_mwdata_a), 64'(32'h0));
    chk("rst_mresp", 64'(mresp_a), 64'(4'b0000));
    chk("rst_wdog", 64'(wdog_a), 64'(1'b0));
    chk("rst_busy_b", 64'(busy_b), 64'(1'b0));
    rst = 1'b1;
    tick();

    // Round-robin: all four pending continuously, single-cycle cache.
    for (int i = 0; i < NA; i++) set_a(i, 1'b1, 4'b0000, 32'h2000_0000 + 32'(i * 16), 32'h0);
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("rr_gnt", 64'(gnt_a), 64'(rr_exp[r]));
      chk("rr_c_mrd", 64'(c_mrd_a), 64'(1'b1));
      chk("rr_c_maddr", 64'(c_maddr_a), 64'(32'h2000_0000 + 32'(rr_exp[r] * 16)));
      push_a(rr_exp[r], 32'hC0DE_0000 + 32'(r));
      c_mresp_a = 1'b1;
      c_mrdata_a = 32'hC0DE_0000 + 32'(r);
      tick();
      c_mresp_a = 1'b0;
      chk("rr_idle_busy", 64'(busy_a), 64'(1'b0));
    end
    mrd_a = '0;

    // Single transactions from the vector table.
    for (int v = 0; v < 4; v++) begin
      set_a(vecs[v].id, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      tick();
      chk("vec_c_mrd", 64'(c_mrd_a), 64'(vecs[v].exp_rd));
      chk("vec_c_mwr", 64'(c_mwr_a), 64'(vecs[v].exp_wr));
      chk("vec_c_maddr", 64'(c_maddr_a), 64'(vecs[v].addr));
      chk("vec_c_mwdata", 64'(c_mwdata_a), 64'(vecs[v].wdata));
      chk("vec_gnt", 64'(gnt_a), 64'(vecs[v].id));
      chk("vec_busy", 64'(busy_a), 64'(1'b1));
      for (int w = 0; w < vecs[v].lat; w++) begin
        tick();
        chk("vec_wait_busy", 64'(busy_a), 64'(1'b1));
        chk("vec_wait_c_maddr", 64'(c_maddr_a), 64'(vecs[v].addr));
      end
      push_a(vecs[v].id, vecs[v].rdata);
      c_mresp_a = 1'b1;
      c_mrdata_a = vecs[v].rdata;
      tick();
      c_mresp_a = 1'b0;
      set_a(vecs[v].id, 1'b0, 4'b0000, vecs[v].addr, vecs[v].wdata);
      chk("vec_done_busy", 64'(busy_a), 64'(1'b0));
      chk("vec_done_c_mrd", 64'(c_mrd_a), 64'(1'b0));
      chk("vec_done_c_mwr", 64'(c_mwr_a), 64'(4'b0000));
    end

    // Requester 1 withdraws a write before the cache answers.
    set_a(1, 1'b1, 4'b0011, 32'h1000_0008, 32'h7777_0000);
    tick();
    chk("abn_c_mwr", 64'(c_mwr_a), 64'(4'b0011));
    chk("abn_c_mrd", 64'(c_mrd_a), 64'(1'b0));
    tick();
    set_a(1, 1'b0, 4'b0000, 32'h1000_0008, 32'h7777_0000);
    tick();
    tick();
    chk("abn_hold_c_mwr", 64'(c_mwr_a), 64'(4'b0011));
    chk("abn_hold_c_maddr", 64'(c_maddr_a), 64'(32'h1000_0008));
    chk("abn_hold_busy", 64'(busy_a), 64'(1'b1));
    c_mresp_a = 1'b1;
    c_mrdata_a = 32'h1111_2222;
    #1;
    chk("abn_no_mresp", 64'(mresp_a), 64'(4'b0000));
    tick();
    c_mresp_a = 1'b0;
    chk("abn_done_busy", 64'(busy_a), 64'(1'b0));

    // Stall blocks new grants but not an in-flight transaction.
    stall_a = 1'b1;
    set_a(0, 1'b1, 4'b0000, 32'h5000_0000, 32'h0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_c_mrd", 64'(c_mrd_a), 64'(1'b0));
      chk("stall_busy", 64'(busy_a), 64'(1'b0));
    end
    stall_a = 1'b0;
    tick();
    chk("unstall_c_mrd", 64'(c_mrd_a), 64'(1'b1));
    chk("unstall_gnt", 64'(gnt_a), 64'(2'd0));
    stall_a = 1'b1;
    tick();
    chk("stall_busy_hold", 64'(busy_a), 64'(1'b1));
    chk("stall_c_mrd_hold", 64'(c_mrd_a), 64'(1'b1));
    push_a(0, 32'h5555_AAAA);
    c_mresp_a = 1'b1;
    c_mrdata_a = 32'h5555_AAAA;
    tick();
    c_mresp_a = 1'b0;
    stall_a = 1'b0;
    set_a(0, 1'b0, 4'b0000, 32'h5000_0000, 32'h0);
    chk("stall_done_busy", 64'(busy_a), 64'(1'b0));

    // Stray completion while idle is ignored.
    c_mresp_a = 1'b1;
    c_mrdata_a = 32'h9999_9999;
    #1;
    chk("stray_idle_mresp", 64'(mresp_a), 64'(4'b0000));
    tick();
    c_mresp_a = 1'b0;
    chk("stray_idle_busy", 64'(busy_a), 64'(1'b0));
    chk("stray_idle_c_mrd", 64'(c_mrd_a), 64'(1'b0));

    // Silent cache: watchdog (when built) or indefinite wait.
    set_a(2, 1'b1, 4'b0000, 32'h6000_0000, 32'h0);
    tick();
    chk("wd_gnt", 64'(gnt_a), 64'(2'd2));
    chk("wd_busy", 64'(busy_a), 64'(1'b1));
`ifdef RVTU_MEM_ARB_WDOG_EN
    repeat (7) tick();
    chk("wd_last_busy", 64'(busy_a), 64'(1'b1));
    chk("wd_not_yet", 64'(wdog_a), 64'(1'b0));
    tick();
    chk("wd_err", 64'(wdog_a), 64'(1'b1));
    chk("wd_idle_busy", 64'(busy_a), 64'(1'b0));
    chk("wd_idle_c_mrd", 64'(c_mrd_a), 64'(1'b0));
    c_mresp_a = 1'b1;
    #1;
    chk("wd_stray_mresp", 64'(mresp_a), 64'(4'b0000));
    tick();
    c_mresp_a = 1'b0;
    chk("wd_regrant_busy", 64'(busy_a), 64'(1'b1));
    chk("wd_regrant_gnt", 64'(gnt_a), 64'(2'd2));
    chk("wd_sticky", 64'(wdog_a), 64'(1'b1));
`else
    repeat (12) tick();
    chk("nowd_busy", 64'(busy_a), 64'(1'b1));
    chk("nowd_err", 64'(wdog_a), 64'(1'b0));
`endif
    push_a(2, 32'h6666_0002);
    c_mresp_a = 1'b1;
    c_mrdata_a = 32'h6666_0002;
    tick();
    c_mresp_a = 1'b0;
    set_a(2, 1'b0, 4'b0000, 32'h6000_0000, 32'h0);
    chk("wd_done_busy", 64'(busy_a), 64'(1'b0));

    // Fixed priority: r0 starves r2 until r0 drops.
    set_b(0, 1'b1, 32'h7000_0000);
    set_b(2, 1'b1, 32'h7000_0020);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("fp_gnt0", 64'(gnt_b), 64'(2'd0));
      chk("fp_c_maddr0", 64'(c_maddr_b), 64'(32'h7000_0000));
      push_b(0, 32'hB0B0_0000 + 32'(r));
      c_mresp_b = 1'b1;
      c_mrdata_b = 32'hB0B0_0000 + 32'(r);
      tick();
      c_mresp_b = 1'b0;
      if (r == 2) set_b(0, 1'b0, 32'h7000_0000);
    end
    tick();
    chk("fp_gnt2", 64'(gnt_b), 64'(2'd2));
    chk("fp_c_mrd2", 64'(c_mrd_b), 64'(1'b1));
    chk("fp_c_maddr2", 64'(c_maddr_b), 64'(32'h7000_0020));
    push_b(2, 32'hB2B2_B2B2);
    c_mresp_b = 1'b1;
    c_mrdata_b = 32'hB2B2_B2B2;
    tick();
    c_mresp_b = 1'b0;
    set_b(2, 1'b0, 32'h7000_0020);
    chk("fp_done_busy", 64'(busy_b), 64'(1'b0));

    @(negedge clk);
    #1;
    chk("sb_a_drained", 64'(q_a.size()), 64'(0));
    chk("sb_b_drained", 64'(q_b.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
